// File: rtl/cve2_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// cve2_multdiv_arbiter: round-robin sharing of one multi-cycle mult/div unit
// Revision 1.0
// ============================================================================
module cve2_multdiv_arbiter #(
  parameter int NumReq    = 2,
  parameter int MaxCycles = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*2-1:0]    req_op_i,
  input  logic [NumReq*2-1:0]    req_signed_mode_i,
  input  logic [NumReq*32-1:0]   req_op_a_i,
  input  logic [NumReq*32-1:0]   req_op_b_i,
  input  logic [NumReq-1:0]      kill_i,
  output logic [NumReq-1:0]      rsp_valid_o,
  input  logic [NumReq-1:0]      rsp_ready_i,
  output logic [31:0]            rsp_result_o,
  output logic                   rsp_err_o,
  output logic                   mult_en_o,
  output logic                   div_en_o,
  output logic                   mult_sel_o,
  output logic                   div_sel_o,
  output logic [1:0]             operator_o,
  output logic [1:0]             signed_mode_o,
  output logic [31:0]            op_a_o,
  output logic [31:0]            op_b_o,
  input  logic                   unit_valid_i,
  input  logic [31:0]            unit_result_i,
  output logic                   busy_o
);

  localparam int PtrW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, owner_q;
  logic [1:0]        op_q, sm_q;
  logic [31:0]       a_q, b_q, res_q;
  logic              err_q;
  logic [CntW-1:0]   cnt_q, cnt_inc;

  logic [NumReq-1:0] eligible, rot;
  logic              grant_any, kill_owner, timeout;
  logic [PtrW-1:0]   winner, winner_inc;

  assign eligible   = req_valid_i & ~kill_i;
  assign kill_owner = kill_i[owner_q];
  assign cnt_inc    = cnt_q + CntW'(1);
  assign timeout    = (cnt_inc == CntW'(MaxCycles));

  // Rotate so bit 0 is the pointer position; lowest set bit is the winner.
  always_comb begin
    rot       = NumReq'({eligible, eligible} >> ptr_q);
    grant_any = |eligible;
    winner    = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) winner = PtrW'((int'(ptr_q) + i) % NumReq);
    end
    winner_inc = PtrW'((int'(winner) + 1) % NumReq);
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    rsp_result_o  = '0;
    rsp_err_o     = 1'b0;
    mult_en_o     = 1'b0;
    div_en_o      = 1'b0;
    mult_sel_o    = 1'b0;
    div_sel_o     = 1'b0;
    operator_o    = '0;
    signed_mode_o = '0;
    op_a_o        = '0;
    op_b_o        = '0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_any && !rst_i) begin
          req_ready_o[winner] = 1'b1;
          state_d             = BUSY;
        end
      end
      BUSY: begin
        operator_o    = op_q;
        signed_mode_o = sm_q;
        op_a_o        = a_q;
        op_b_o        = b_q;
        if (kill_owner) begin
          state_d = IDLE;
        end else begin
          mult_en_o  = ~op_q[1];
          mult_sel_o = ~op_q[1];
          div_en_o   = op_q[1];
          div_sel_o  = op_q[1];
          if (unit_valid_i || timeout) state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        rsp_result_o         = res_q;
        rsp_err_o            = err_q;
        if (kill_owner || rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      sm_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            for (int i = 0; i < NumReq; i++) begin
              if (PtrW'(i) == winner) begin
                op_q <= req_op_i[2*i +: 2];
                sm_q <= req_signed_mode_i[2*i +: 2];
                a_q  <= req_op_a_i[32*i +: 32];
                b_q  <= req_op_b_i[32*i +: 32];
              end
            end
            owner_q <= winner;
            ptr_q   <= winner_inc;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_inc;
          if (!kill_owner) begin
            if (unit_valid_i) begin
              res_q <= unit_result_i;
              err_q <= 1'b0;
            end else if (timeout) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cve2_multdiv_arbiter.sv
`default_nettype none
// Testbench for cve2_multdiv_arbiter: directed vector table plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_cve2_multdiv_arbiter;
  localparam int NR = 3;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, kill = '0, rsp_valid, rsp_ready = '0;
  logic [NR*2-1:0] req_op = '0, req_sm = '0;
  logic [NR*32-1:0] req_a = '0, req_b = '0;
  logic [31:0] rsp_result, op_a, op_b, unit_result = '0;
  logic rsp_err, mult_en, div_en, mult_sel, div_sel, unit_valid = 1'b0, busy;
  logic [1:0] oper, smode;

  always #5 clk = ~clk;

  cve2_multdiv_arbiter #(.NumReq(NR), .MaxCycles(MC)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_signed_mode_i(req_sm), .req_op_a_i(req_a), .req_op_b_i(req_b),
    .kill_i(kill), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_err_o(rsp_err), .mult_en_o(mult_en), .div_en_o(div_en),
    .mult_sel_o(mult_sel), .div_sel_o(div_sel), .operator_o(oper), .signed_mode_o(smode),
    .op_a_o(op_a), .op_b_o(op_b), .unit_valid_i(unit_valid), .unit_result_i(unit_result),
    .busy_o(busy)
  );

  typedef struct packed {
    logic [NR-1:0] ready, rspv;
    logic [31:0] res;
    logic err, men, den, msel, dsel;
    logic [1:0] oper, sm;
    logic [31:0] a, b;
    logic busy;
  } out_t;

  typedef struct packed {
    logic [NR-1:0] rv, kl, rr;
    logic uv;
    logic [31:0] ur;
    logic [NR-1:0] ready, rspv;
    logic [31:0] res;
    logic err, men, den, busy;
  } vec_t;

  int vectors = 0;
  int errors  = 0;

  // Reference model: phase 0 idle, 1 operation running, 2 response pending.
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_cnt = 0;
  logic [1:0] m_op = '0, m_sm = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic m_err = 1'b0;

  function automatic int pick();
    for (int k = 0; k < NR; k++) begin
      int n = (m_ptr + k) % NR;
      if (req_valid[n] && !kill[n]) return n;
    end
    return -1;
  endfunction

  function automatic out_t model_out();
    out_t o = '0;
    int w = pick();
    if (m_phase == 0) begin
      if (w >= 0) o.ready[w] = 1'b1;
    end else if (m_phase == 1) begin
      o.busy = 1'b1;
      o.oper = m_op; o.sm = m_sm; o.a = m_a; o.b = m_b;
      if (!kill[m_owner]) begin
        o.men = (m_op < 2); o.msel = (m_op < 2);
        o.den = (m_op >= 2); o.dsel = (m_op >= 2);
      end
    end else begin
      o.busy = 1'b1;
      o.rspv[m_owner] = 1'b1;
      o.res = m_res;
      o.err = m_err;
    end
    return o;
  endfunction

  task automatic model_step();
    int w = pick();
    if (m_phase == 0) begin
      if (w >= 0) begin
        m_owner = w; m_op = req_op[2*w +: 2]; m_sm = req_sm[2*w +: 2];
        m_a = req_a[32*w +: 32]; m_b = req_b[32*w +: 32];
        m_ptr = (w + 1) % NR; m_cnt = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_cnt++;
      if (kill[m_owner]) m_phase = 0;
      else if (unit_valid) begin m_res = unit_result; m_err = 1'b0; m_phase = 2; end
      else if (m_cnt == MC) begin m_res = '0; m_err = 1'b1; m_phase = 2; end
    end else if (kill[m_owner] || rsp_ready[m_owner]) begin
      m_phase = 0;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.ready = req_ready; o.rspv = rsp_valid; o.res = rsp_result; o.err = rsp_err;
    o.men = mult_en; o.den = div_en; o.msel = mult_sel; o.dsel = div_sel;
    o.oper = oper; o.sm = smode; o.a = op_a; o.b = op_b; o.busy = busy;
    return o;
  endfunction

  function automatic logic [74:0] tab_act();
    return {req_ready, rsp_valid, rsp_result, rsp_err, mult_en, div_en, busy};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are already applied (just after negedge); compare, then clock.
  task automatic cycle(string name, bit use_tab, logic [74:0] texp);
    #1;
    check(name, 128'(dut_out()), 128'(model_out()));
    if (use_tab) check({name, " table"}, 128'(tab_act()), 128'(texp));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset(string name);
    #2 rst = 1'b1;
    #1 check(name, 128'(dut_out()), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic [2:0] rv, logic [2:0] kl, logic [2:0] rr, logic uv,
                              logic [31:0] ur, logic [2:0] rdy, logic [2:0] rspv,
                              logic [31:0] res, logic err, logic men, logic den, logic bsy);
    return '{rv, kl, rr, uv, ur, rdy, rspv, res, err, men, den, bsy};
  endfunction

  vec_t tab [29];

  initial begin
    // Single mult, contention, divide with backpressure, kill, timeout.
    tab[0]  = mk(3'b001, 0, 0,      0, 0,  3'b001, 0,      0,  0, 0, 0, 0);
    tab[1]  = mk(3'b000, 0, 0,      0, 0,  0,      0,      0,  0, 1, 0, 1);
    tab[2]  = mk(3'b000, 0, 0,      1, 42, 0,      0,      0,  0, 1, 0, 1);
    tab[3]  = mk(3'b000, 0, 3'b001, 0, 0,  0,      3'b001, 42, 0, 0, 0, 1);
    tab[4]  = mk(3'b000, 0, 0,      0, 0,  0,      0,      0,  0, 0, 0, 0);
    tab[5]  = mk(3'b011, 0, 0,      0, 0,  3'b010, 0,      0,  0, 0, 0, 0);
    tab[6]  = mk(3'b011, 0, 0,      0, 0,  0,      0,      0,  0, 0, 1, 1);
    tab[7]  = mk(3'b011, 0, 0,      1, 14, 0,      0,      0,  0, 0, 1, 1);
    tab[8]  = mk(3'b011, 0, 3'b010, 0, 0,  0,      3'b010, 14, 0, 0, 0, 1);
    tab[9]  = mk(3'b011, 0, 0,      0, 0,  3'b001, 0,      0,  0, 0, 0, 0);
    tab[10] = mk(3'b011, 0, 0,      1, 42, 0,      0,      0,  0, 1, 0, 1);
    tab[11] = mk(3'b011, 0, 3'b001, 0, 0,  0,      3'b001, 42, 0, 0, 0, 1);
    tab[12] = mk(3'b011, 0, 0,      0, 0,  3'b010, 0,      0,  0, 0, 0, 0);
    tab[13] = mk(3'b001, 0, 0,      1, 14, 0,      0,      0,  0, 0, 1, 1);
    for (int i = 14; i < 19; i++) tab[i] = mk(3'b001, 0, 0, 0, 0, 0, 3'b010, 14, 0, 0, 0, 1);
    tab[19] = mk(3'b001, 0, 3'b010, 0, 0,  0,      3'b010, 14, 0, 0, 0, 1);
    tab[20] = mk(3'b011, 0, 0,      0, 0,  3'b001, 0,      0,  0, 0, 0, 0);
    tab[21] = mk(3'b010, 3'b001, 0, 1, 99, 0,      0,      0,  0, 0, 0, 1);
    tab[22] = mk(3'b010, 0, 0,      0, 0,  3'b010, 0,      0,  0, 0, 0, 0);
    tab[23] = mk(3'b000, 3'b001, 0, 0, 0,  0,      0,      0,  0, 0, 1, 1);
    for (int i = 24; i < 27; i++) tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tab[27] = mk(3'b000, 0, 3'b010, 0, 0,  0,      3'b010, 0,  1, 0, 0, 1);
    tab[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    req_op = {2'd1, 2'd2, 2'd0};
    req_a  = {32'd3, 32'd100, 32'd7};
    req_b  = {32'd5, 32'd7, 32'd6};

    @(negedge clk);
    #1 check("reset state", 128'(dut_out()), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (tab[i]) begin
      req_valid = tab[i].rv; kill = tab[i].kl; rsp_ready = tab[i].rr;
      unit_valid = tab[i].uv; unit_result = tab[i].ur;
      cycle($sformatf("vec%0d", i), 1'b1,
            {tab[i].ready, tab[i].rspv, tab[i].res, tab[i].err, tab[i].men, tab[i].den, tab[i].busy});
    end

    // Reset mid-operation: pointer sits at 2, req1 wins, then reset.
    req_valid = 3'b010;
    cycle("rst grant", 1'b1, {3'b010, 3'b000, 32'd0, 4'b0000});
    req_valid = 3'b011;
    async_reset("reset mid-busy");
    req_valid = 3'b011;
    cycle("post-reset grant", 1'b1, {3'b001, 3'b000, 32'd0, 4'b0000});
    req_valid = '0;
    unit_valid = 1'b1; unit_result = 32'h1234;
    cycle("post-reset busy", 1'b1, {3'b000, 3'b000, 32'd0, 4'b0101});
    unit_valid = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      req_valid   = NR'($urandom);
      kill        = ($urandom_range(0, 11) == 0) ? NR'(1 << $urandom_range(0, NR - 1)) : '0;
      rsp_ready   = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
      unit_valid  = ($urandom_range(0, 3) == 0);
      unit_result = $urandom;
      for (int n = 0; n < NR; n++) begin
        req_op[2*n +: 2] = 2'($urandom);
        req_sm[2*n +: 2] = 2'($urandom);
        req_a[32*n +: 32] = $urandom;
        req_b[32*n +: 32] = $urandom;
      end
      if ($urandom_range(0, 499) == 0) async_reset("random reset");
      else cycle($sformatf("rand%0d", c), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
